ysyx_22040386_mem_arbiter: RTL and testbench

Two-requester memory arbiter that shares the single downstream memory port between the instruction-fetch unit (read-only) and the memory-access unit (load/store). It grants one requester at a time, registers the winning request, drives a valid/ready request channel to memory and routes the response back to the owner. It sits between IFU/MEMU and the memory model.

---
 rtl/ysyx_22040386_arb_pkg.sv | 19 +
 rtl/ysyx_22040386_arb_pick.sv | 26 ++
 rtl/ysyx_22040386_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_ysyx_22040386_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040386_arb_pkg.sv
// Shared types for the IFU/MEMU memory arbiter.
// FSM state and owner encodings plus default bus widths.
package ysyx_22040386_arb_pkg;

  localparam int ARB_ADDR_W = 64;
  localparam int ARB_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_22040386_arb_pick.sv
// Winner selection between the fetch and data requesters.
// Build option: ARB_RR_EN selects round-robin, default is MEM-first.
module ysyx_22040386_arb_pick
  import ysyx_22040386_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       mem_req,
  input  arb_owner_e last_owner,
  output logic       grant_if,
  output logic       grant_mem
);

`ifdef ARB_RR_EN
  // on contention, hand the port to whoever did not hold it last
  assign grant_mem = mem_req & (~if_req | (last_owner == OWN_IF));
  assign grant_if  = if_req & ~grant_mem;
`else
  logic unused_last;
  assign unused_last = last_owner;

  // data side always wins a contested grant
  assign grant_mem = mem_req;
  assign grant_if  = if_req & ~mem_req;
`endif

endmodule

// File: rtl/ysyx_22040386_mem_arbiter.sv
// Shares one downstream memory port between IFU and MEMU.
// Build option: ARB_RR_EN enables round-robin grant selection.
module ysyx_22040386_mem_arbiter
  import ysyx_22040386_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                i_ARB_clk,
  input  logic                i_ARB_rst_n,
  input  logic                i_ARB_if_req,
  input  logic [ADDR_W-1:0]   i_ARB_if_addr,
  output logic                o_ARB_if_ack,
  output logic [DATA_W-1:0]   o_ARB_if_rdata,
  input  logic                i_ARB_mem_req,
  input  logic                i_ARB_mem_we,
  input  logic [ADDR_W-1:0]   i_ARB_mem_addr,
  input  logic [DATA_W-1:0]   i_ARB_mem_wdata,
  input  logic [DATA_W/8-1:0] i_ARB_mem_wmask,
  output logic                o_ARB_mem_ack,
  output logic [DATA_W-1:0]   o_ARB_mem_rdata,
  output logic                o_ARB_req_valid,
  input  logic                i_ARB_req_ready,
  output logic                o_ARB_req_we,
  output logic [ADDR_W-1:0]   o_ARB_req_addr,
  output logic [DATA_W-1:0]   o_ARB_req_wdata,
  output logic [DATA_W/8-1:0] o_ARB_req_wmask,
  input  logic                i_ARB_resp_valid,
  input  logic [DATA_W-1:0]   i_ARB_resp_data,
  output logic                o_ARB_busy
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e state;
  arb_owner_e owner;
  arb_owner_e last_owner;
  logic       grant_if;
  logic       grant_mem;

  ysyx_22040386_arb_pick u_pick (
    .if_req     (i_ARB_if_req),
    .mem_req    (i_ARB_mem_req),
    .last_owner (last_owner),
    .grant_if   (grant_if),
    .grant_mem  (grant_mem)
  );

`ifdef ARB_RR_EN
  // remember who got the port on every grant
  always_ff @(posedge i_ARB_clk or negedge i_ARB_rst_n) begin
    if (!i_ARB_rst_n) begin
      last_owner <= OWN_MEM;
    end else if (state == IDLE) begin
      if (grant_mem) begin
        last_owner <= OWN_MEM;
      end else if (grant_if) begin
        last_owner <= OWN_IF;
      end
    end
  end
`else
  assign last_owner = OWN_MEM;
`endif

  // grant, hold the request, then route the response to its owner
  always_ff @(posedge i_ARB_clk or negedge i_ARB_rst_n) begin
    if (!i_ARB_rst_n) begin
      state           <= IDLE;
      owner           <= OWN_IF;
      o_ARB_req_we    <= 1'b0;
      o_ARB_req_addr  <= '0;
      o_ARB_req_wdata <= '0;
      o_ARB_req_wmask <= '0;
      o_ARB_if_ack    <= 1'b0;
      o_ARB_mem_ack   <= 1'b0;
      o_ARB_if_rdata  <= '0;
      o_ARB_mem_rdata <= '0;
    end else begin
      o_ARB_if_ack  <= 1'b0;
      o_ARB_mem_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_mem) begin
            owner           <= OWN_MEM;
            o_ARB_req_we    <= i_ARB_mem_we;
            o_ARB_req_addr  <= i_ARB_mem_addr;
            o_ARB_req_wdata <= i_ARB_mem_wdata;
            o_ARB_req_wmask <= i_ARB_mem_wmask;
            state           <= REQ;
          end else if (grant_if) begin
            owner           <= OWN_IF;
            o_ARB_req_we    <= 1'b0;
            o_ARB_req_addr  <= i_ARB_if_addr;
            o_ARB_req_wdata <= '0;
            o_ARB_req_wmask <= {MASK_W{1'b0}};
            state           <= REQ;
          end
        end
        REQ: begin
          if (i_ARB_req_ready) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (i_ARB_resp_valid) begin
            state <= IDLE;
            if (owner == OWN_MEM) begin
              o_ARB_mem_ack   <= 1'b1;
              o_ARB_mem_rdata <= i_ARB_resp_data;
            end else begin
              o_ARB_if_ack    <= 1'b1;
              o_ARB_if_rdata  <= i_ARB_resp_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ARB_req_valid = (state == REQ);
  assign o_ARB_busy      = (state != IDLE);

endmodule

// File: tb/tb_ysyx_22040386_mem_arbiter.sv
// Bench for the IFU/MEMU memory arbiter.
// Transaction-level model predicts grants, acks and read data.
module tb_ysyx_22040386_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack;
  logic [63:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        busy;

  int passed;
  int total;

  ysyx_22040386_mem_arbiter dut (
    .i_ARB_clk        (clk),
    .i_ARB_rst_n      (rst_n),
    .i_ARB_if_req     (if_req),
    .i_ARB_if_addr    (if_addr),
    .o_ARB_if_ack     (if_ack),
    .o_ARB_if_rdata   (if_rdata),
    .i_ARB_mem_req    (mem_req),
    .i_ARB_mem_we     (mem_we),
    .i_ARB_mem_addr   (mem_addr),
    .i_ARB_mem_wdata  (mem_wdata),
    .i_ARB_mem_wmask  (mem_wmask),
    .o_ARB_mem_ack    (mem_ack),
    .o_ARB_mem_rdata  (mem_rdata),
    .o_ARB_req_valid  (req_valid),
    .i_ARB_req_ready  (req_ready),
    .o_ARB_req_we     (req_we),
    .o_ARB_req_addr   (req_addr),
    .o_ARB_req_wdata  (req_wdata),
    .o_ARB_req_wmask  (req_wmask),
    .i_ARB_resp_valid (resp_valid),
    .i_ARB_resp_data  (resp_data),
    .o_ARB_busy       (busy)
  );

  always #5 clk = ~clk;

  // reference model: one outstanding transaction at a time
  bit          m_act;
  bit          m_acc;
  bit          m_own_mem;
  bit          m_last_mem;
  bit          m_ack_if;
  bit          m_ack_mem;
  bit          m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wmask;
  logic [63:0] m_rd_if;
  logic [63:0] m_rd_mem;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit pick_mem(bit ir, bit mr, bit last_mem);
`ifdef ARB_RR_EN
    return mr && (!ir || !last_mem);
`else
    return mr;
`endif
  endfunction

  task automatic model_reset();
    m_act      = 0;
    m_acc      = 0;
    m_own_mem  = 0;
    m_last_mem = 1;
    m_ack_if   = 0;
    m_ack_mem  = 0;
    m_rd_if    = '0;
    m_rd_mem   = '0;
  endtask

  // what the next rising edge does, given the inputs now driven
  task automatic model_adv();
    bit w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_ack_if  = 0;
    m_ack_mem = 0;
    if (!m_act) begin
      if (if_req || mem_req) begin
        w          = pick_mem(if_req, mem_req, m_last_mem);
        m_act      = 1;
        m_acc      = 0;
        m_own_mem  = w;
        m_last_mem = w;
        m_we       = w ? mem_we : 1'b0;
        m_addr     = w ? mem_addr : if_addr;
        m_wdata    = mem_wdata;
        m_wmask    = w ? mem_wmask : 8'h00;
      end
    end else if (!m_acc) begin
      if (req_ready) m_acc = 1;
    end else if (resp_valid) begin
      m_act = 0;
      m_acc = 0;
      if (m_own_mem) begin
        m_ack_mem = 1;
        m_rd_mem  = resp_data;
      end else begin
        m_ack_if = 1;
        m_rd_if  = resp_data;
      end
    end
  endtask

  task automatic check_all();
    chk("req_valid", 64'(req_valid), 64'(m_act && !m_acc));
    chk("busy", 64'(busy), 64'(m_act));
    chk("if_ack", 64'(if_ack), 64'(m_ack_if));
    chk("mem_ack", 64'(mem_ack), 64'(m_ack_mem));
    chk("if_rdata", if_rdata, m_rd_if);
    chk("mem_rdata", mem_rdata, m_rd_mem);
    if (m_act && !m_acc) begin
      chk("req_addr", req_addr, m_addr);
      chk("req_we", 64'(req_we), 64'(m_we));
      chk("req_wmask", 64'(req_wmask), 64'(m_wmask));
      if (m_own_mem) chk("req_wdata", req_wdata, m_wdata);
    end
  endtask

  task automatic cycle();
    model_adv();
    @(negedge clk);
    check_all();
  endtask

  task automatic drain();
    if_req     = 0;
    mem_req    = 0;
    req_ready  = 1;
    resp_valid = 1;
    repeat (6) cycle();
  endtask

  task automatic do_reset();
    rst_n      = 0;
    if_req     = 0;
    mem_req    = 0;
    req_ready  = 0;
    resp_valid = 0;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1;
  endtask

  int cnt_if;
  int cnt_mem;
  int cnt_tail;
  int first_if;

  initial begin
    clk        = 0;
    passed     = 0;
    total      = 0;
    rst_n      = 0;
    if_req     = 0;
    if_addr    = '0;
    mem_req    = 0;
    mem_we     = 0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    req_ready  = 0;
    resp_valid = 0;
    resp_data  = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // IF alone against zero-wait memory
    drain();
    if_req     = 1;
    if_addr    = 64'h8000_0000;
    resp_data  = 64'h0000_0013_0000_0093;
    cycle();
    chk("if_addr_n1", req_addr, 64'h8000_0000);
    chk("if_we_n1", 64'(req_we), 64'd0);
    cycle();
    cycle();
    chk("if_ack_n3", 64'(if_ack), 64'd1);
    chk("if_rdata_n3", if_rdata, 64'h0000_0013_0000_0093);
    chk("mem_ack_n3", 64'(mem_ack), 64'd0);
    if_req = 0;

    // MEM write, ready held off, stray responses in REQ
    drain();
    mem_req    = 1;
    mem_we     = 1;
    mem_addr   = 64'h8000_1000;
    mem_wdata  = 64'hDEAD_BEEF;
    mem_wmask  = 8'h0F;
    req_ready  = 0;
    resp_valid = 1;
    resp_data  = 64'h1111_2222_3333_4444;
    cycle();
    repeat (4) cycle();
    req_ready  = 1;
    resp_valid = 0;
    cycle();
    mem_req   = 0;
    req_ready = 0;
    cycle();
    cycle();
    resp_valid = 1;
    resp_data  = 64'h0000_0000_CAFE_F00D;
    cycle();
    chk("mem_ack_k1", 64'(mem_ack), 64'd1);
    chk("mem_rdata_k1", mem_rdata, 64'h0000_0000_CAFE_F00D);
    resp_valid = 0;
    cycle();
    chk("mem_ack_pulse", 64'(mem_ack), 64'd0);

    // reset while a MEM read waits in REQ
    drain();
    mem_req    = 1;
    mem_we     = 0;
    mem_addr   = 64'h8000_0010;
    req_ready  = 0;
    resp_valid = 0;
    cycle();
    cycle();
    rst_n = 0;
    #1;
    chk("rst_valid", 64'(req_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_if_ack", 64'(if_ack), 64'd0);
    chk("rst_mem_ack", 64'(mem_ack), 64'd0);
    chk("rst_mem_rdata", mem_rdata, 64'd0);
    model_reset();
    mem_req = 0;
    @(negedge clk);
    check_all();
    rst_n      = 1;
    resp_valid = 1;
    req_ready  = 1;
    repeat (4) cycle();

    // both requesters held high from a fresh reset
    do_reset();
    if_req     = 1;
    if_addr    = 64'h8000_0100;
    mem_req    = 1;
    mem_we     = 0;
    mem_addr   = 64'h8000_2000;
    req_ready  = 1;
    resp_valid = 1;
    resp_data  = 64'h0123_4567_89AB_CDEF;
    cnt_if     = 0;
    cnt_mem    = 0;
    first_if   = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      cnt_if  += int'(if_ack);
      cnt_mem += int'(mem_ack);
      if (i == 3) first_if = int'(if_ack);
    end
    mem_req  = 0;
    cnt_tail = 0;
    repeat (3) begin
      cycle();
      cnt_tail += int'(if_ack);
    end
`ifdef ARB_RR_EN
    chk("both_first_if", 64'(first_if), 64'd1);
    chk("both_if_grants", 64'(cnt_if), 64'd2);
    chk("both_mem_grants", 64'(cnt_mem), 64'd2);
`else
    chk("both_first_if", 64'(first_if), 64'd0);
    chk("both_if_grants", 64'(cnt_if), 64'd0);
    chk("both_mem_grants", 64'(cnt_mem), 64'd4);
`endif
    chk("if_after_drop", 64'(cnt_tail), 64'd1);
    drain();

    // randomized traffic with random memory timing
    for (int i = 0; i < 1500; i++) begin
      if (!if_req) begin
        if ($urandom_range(0, 1) == 1) begin
          if_req  = 1;
          if_addr = {$urandom, $urandom};
        end
      end else if (m_ack_if) begin
        if ($urandom_range(0, 3) == 0) begin
          if_addr = {$urandom, $urandom};
        end else begin
          if_req = 0;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        if_req = 0;
      end
      if (!mem_req) begin
        if ($urandom_range(0, 1) == 1) begin
          mem_req   = 1;
          mem_we    = 1'($urandom_range(0, 1));
          mem_addr  = {$urandom, $urandom};
          mem_wdata = {$urandom, $urandom};
          mem_wmask = 8'($urandom);
        end
      end else if (m_ack_mem) begin
        if ($urandom_range(0, 3) == 0) begin
          mem_addr  = {$urandom, $urandom};
          mem_wdata = {$urandom, $urandom};
        end else begin
          mem_req = 0;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        mem_req = 0;
      end
      req_ready  = 1'($urandom_range(0, 1));
      resp_valid = ($urandom_range(0, 2) != 0);
      resp_data  = {$urandom, $urandom};
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
